arcade_input_mapper: RTL
========================

Name: arcade_input_mapper

Overview:
- Sits directly upstream of the galaxian core's player-input ports.
- Decodes the HPS ps2_key strobe protocol into held-key latches and merges them with both joysticks.
- Applies the orientation remap and generates a timed coin pulse from start presses.
- Drives registered P1_CSJUDLR / P2_CSJUDLR vectors, replacing the ad-hoc keyboard logic in the top level.

Parameters:
- COIN_PULSE_CYCLES, 1200000, coin-high duration in clk_sys cycles (100 ms at 12 MHz); must be >= 1.
- CNT_W, 21, coin counter width; must satisfy 2^CNT_W > COIN_PULSE_CYCLES.

Ports:
- clk_sys  input  1  system clock (12 MHz domain, same as hps_io).
- reset_n  input  1  asynchronous active-low reset.
- ps2_key  input  11  [10] toggle strobe, [9] pressed, [8:0] scan code (bit 8 = extended).
- joystick_0  input  16  [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2.
- joystick_1  input  16  same layout; OR-merged with joystick_0.
- rotate  input  1  1 = horizontal orientation (status[2]); remaps directions.
- P1_CSJUDLR  output  7  {coin,start1,fire,up,down,left,right}.
- P2_CSJUDLR  output  7  {1'b0,start2,fire,up,down,left,right}.
- coin_busy  output  1  high while coin FSM is not IDLE (debug/LED).

Behaviour:
- Reset: all key latches, strobe history, counter and outputs = 0; FSM = IDLE. Deassertion is synchronised by the caller; no key event is lost or generated on release.
- Strobe detection: register ps2_key[10] into old_strobe every cycle. An event occurs on the cycle where ps2_key[10] != old_strobe; at that edge the latch selected by the code loads ps2_key[9].
- Code map (bit 8 don't-care for arrows):
  - X75 up, X72 down, X6B left, X74 right.
  - 029 fire_space, 014 fire_ctrl (separate latches).
  - 005 start1, 006 start2, 02E coin_key.
  - Any other code: no latch changes.
- fire = fire_space | fire_ctrl | joy[4]. Releasing one fire key never clears the other.
- Orientation (rotate=1): up=left_k|joy[1], down=right_k|joy[0], left=down_k|joy[2], right=up_k|joy[3]. With rotate=0, direct mapping.
- start1 = start1_k|joy[5]; start2 = start2_k|joy[6].
- coin_req = start1|start2|coin_key. rise = coin_req & ~coin_req_d (coin_req_d registered).
- Coin FSM:
  - IDLE: coin=0. On rise, go to PULSE and load cnt=COIN_PULSE_CYCLES-1.
  - PULSE: coin=1, cnt decrements each cycle. When cnt==0, go to HOLD.
  - HOLD: coin=0. Stay while coin_req=1; go to IDLE on the first cycle coin_req=0.
  - Rises during PULSE or HOLD are ignored: no retrigger and no counter extension.
- Coin pulse is exactly COIN_PULSE_CYCLES cycles, independent of how long the key is held.
- Latency:
  - All outputs are registered. A joystick/rotate change appears on the outputs 1 edge later.
  - A ps2 event detected at edge k is visible at edge k+1.
  - Coin rises at the edge after the edge that registers the rise, i.e. 2 edges after coin_req goes high.
- Simultaneous events: the strobe toggle and joystick changes in the same cycle are both applied. Start1 and start2 rising together give one coin pulse.
- P2 coin bit is constant 0. P2 start = start2; other P2 bits equal the P1 equivalents.

Decomposition:
- Shared package arcade_input_pkg:
  - Scan-code localparams (SC_UP=8'h75, ...).
  - Joystick bit indices.
  - CSJUDLR bit positions.
  - Coin FSM state enum {IDLE,PULSE,HOLD}.
- One sub-module, coin_pulse_gen: rise detect, FSM and counter, parameterised by COIN_PULSE_CYCLES/CNT_W. Ports: clk_sys, reset_n, req, coin, busy.
- Key decode and remap stay in the top of arcade_input_mapper.

Test Plan (COIN_PULSE_CYCLES=8 for sim):
- Reset, toggle strobe with {pressed=1, code=9'h175} → P1[3]=1 two edges after the toggle. Then toggle with pressed=0 → P1[3]=0.
- Space press, ctrl press, space release → fire remains 1. Ctrl release → fire=0.
- rotate=1, joystick_0=16'h0008 (up) → P1 right bit [0]=1, up bit [3]=0. rotate=0 → P1[3]=1.
- joystick_0[5] held 40 cycles → P1[6] (coin) high exactly 8 cycles starting 2 edges after assertion; coin_busy low the cycle after release.
- Start2 pressed during PULSE and released during HOLD → still a single 8-cycle pulse; a new press after IDLE → second 8-cycle pulse.
- Assert reset_n=0 mid-PULSE → coin=0 and all outputs 0 immediately (async). After release with keys idle, the outputs stay 0.

Source files
------------

// File: rtl/arcade_input_mapper_pkg.sv
// Shared constants for the arcade input mapper: scan codes, joystick and
// CSJUDLR bit positions, key-latch bundle and coin FSM states.
package arcade_input_pkg;

  // Arrow codes compare only the low byte, so the extended prefix is ignored.
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [8:0] SC_SPACE  = 9'h029;
  localparam logic [8:0] SC_CTRL   = 9'h014;
  localparam logic [8:0] SC_START1 = 9'h005;
  localparam logic [8:0] SC_START2 = 9'h006;
  localparam logic [8:0] SC_COIN   = 9'h02E;

  localparam int PS2_STROBE  = 10;
  localparam int PS2_PRESSED = 9;

  localparam int JOY_R      = 0;
  localparam int JOY_L      = 1;
  localparam int JOY_D      = 2;
  localparam int JOY_U      = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;

  localparam int B_RIGHT = 0;
  localparam int B_LEFT  = 1;
  localparam int B_DOWN  = 2;
  localparam int B_UP    = 3;
  localparam int B_FIRE  = 4;
  localparam int B_START = 5;
  localparam int B_COIN  = 6;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic fire_space;
    logic fire_ctrl;
    logic start1;
    logic start2;
    logic coin;
  } keys_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } coin_state_e;

endpackage

// File: rtl/arcade_input_mapper_if.sv
// Player-input bundle between the HPS/joystick side and the galaxian core.
interface arcade_input_mapper_if;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        rotate;
  logic [6:0]  P1_CSJUDLR;
  logic [6:0]  P2_CSJUDLR;
  logic        coin_busy;

  modport master (
    output ps2_key, joystick_0, joystick_1, rotate,
    input  P1_CSJUDLR, P2_CSJUDLR, coin_busy
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1, rotate,
    output P1_CSJUDLR, P2_CSJUDLR, coin_busy
  );
endinterface

// File: rtl/arcade_input_mapper_coin_pulse_gen.sv
// Fixed-length coin pulse from the rising edge of a request; further requests
// are ignored until the request has been released after the pulse.
module coin_pulse_gen
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE_CYCLES = 1200000,
  parameter int CNT_W             = 21
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req,
  output logic coin,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COIN_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  coin_state_e      r_state;
  coin_state_e      w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_req_d;
  logic             w_rise;

  assign w_rise = req & ~r_req_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req_d <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_req_d <= req;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_next = PULSE;
          w_cnt_next   = CNT_LOAD;
        end
      end
      PULSE: begin
        if (r_cnt == '0) begin
          w_state_next = HOLD;
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      HOLD: begin
        // Wait for a full release so a held key cannot retrigger.
        if (!req) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign coin = (r_state == PULSE);
  assign busy = (r_state != IDLE);

endmodule

// File: rtl/arcade_input_mapper.sv
// Keyboard/joystick merge for the galaxian core: ps2 strobe decode into held
// latches, orientation remap, coin pulse, and registered CSJUDLR outputs.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE_CYCLES = 1200000,
  parameter int CNT_W             = 21
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  arcade_input_mapper_if.slave  bus
);

  logic       r_old_strobe;
  keys_t      r_keys;
  keys_t      w_keys_next;
  logic       w_event;
  logic       w_pressed;
  logic [8:0] w_code;
  logic [6:0] w_joy;
  logic       w_up;
  logic       w_down;
  logic       w_left;
  logic       w_right;
  logic       w_fire;
  logic       w_start1;
  logic       w_start2;
  logic       w_coin_req;
  logic       w_coin;
  logic       w_busy;
  logic [6:0] w_p1_next;
  logic [6:0] w_p2_next;
  logic [6:0] r_p1;
  logic [6:0] r_p2;

  assign w_event   = bus.ps2_key[PS2_STROBE] ^ r_old_strobe;
  assign w_pressed = bus.ps2_key[PS2_PRESSED];
  assign w_code    = bus.ps2_key[8:0];
  assign w_joy     = bus.joystick_0[6:0] | bus.joystick_1[6:0];

  always_comb begin
    w_keys_next = r_keys;
    if (w_event) begin
      if (w_code[7:0] == SC_UP) begin
        w_keys_next.up = w_pressed;
      end else if (w_code[7:0] == SC_DOWN) begin
        w_keys_next.down = w_pressed;
      end else if (w_code[7:0] == SC_LEFT) begin
        w_keys_next.left = w_pressed;
      end else if (w_code[7:0] == SC_RIGHT) begin
        w_keys_next.right = w_pressed;
      end else begin
        case (w_code)
          SC_SPACE:  w_keys_next.fire_space = w_pressed;
          SC_CTRL:   w_keys_next.fire_ctrl  = w_pressed;
          SC_START1: w_keys_next.start1     = w_pressed;
          SC_START2: w_keys_next.start2     = w_pressed;
          SC_COIN:   w_keys_next.coin       = w_pressed;
          default:   ;
        endcase
      end
    end
  end

  // Horizontal cabinet: the screen is turned a quarter, so directions rotate.
  always_comb begin
    if (bus.rotate) begin
      w_up    = r_keys.left  | w_joy[JOY_L];
      w_down  = r_keys.right | w_joy[JOY_R];
      w_left  = r_keys.down  | w_joy[JOY_D];
      w_right = r_keys.up    | w_joy[JOY_U];
    end else begin
      w_up    = r_keys.up    | w_joy[JOY_U];
      w_down  = r_keys.down  | w_joy[JOY_D];
      w_left  = r_keys.left  | w_joy[JOY_L];
      w_right = r_keys.right | w_joy[JOY_R];
    end
  end

  assign w_fire     = r_keys.fire_space | r_keys.fire_ctrl | w_joy[JOY_FIRE];
  assign w_start1   = r_keys.start1 | w_joy[JOY_START1];
  assign w_start2   = r_keys.start2 | w_joy[JOY_START2];
  assign w_coin_req = w_start1 | w_start2 | r_keys.coin;

  coin_pulse_gen #(
    .COIN_PULSE_CYCLES (COIN_PULSE_CYCLES),
    .CNT_W             (CNT_W)
  ) u_coin (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .req     (w_coin_req),
    .coin    (w_coin),
    .busy    (w_busy)
  );

  always_comb begin
    w_p1_next          = '0;
    w_p1_next[B_RIGHT] = w_right;
    w_p1_next[B_LEFT]  = w_left;
    w_p1_next[B_DOWN]  = w_down;
    w_p1_next[B_UP]    = w_up;
    w_p1_next[B_FIRE]  = w_fire;
    w_p1_next[B_START] = w_start1;
    w_p1_next[B_COIN]  = w_coin;
    w_p2_next          = w_p1_next;
    w_p2_next[B_START] = w_start2;
    w_p2_next[B_COIN]  = 1'b0;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_old_strobe <= 1'b0;
      r_keys       <= '0;
      r_p1         <= '0;
      r_p2         <= '0;
    end else begin
      r_old_strobe <= bus.ps2_key[PS2_STROBE];
      r_keys       <= w_keys_next;
      r_p1         <= w_p1_next;
      r_p2         <= w_p2_next;
    end
  end

  assign bus.P1_CSJUDLR = r_p1;
  assign bus.P2_CSJUDLR = r_p2;
  assign bus.coin_busy  = w_busy;

endmodule
